// File: rtl/traceback_column_writer_pkg.sv
// Shared widths, stop code and FSM states for the traceback column writer.
package traceback_column_writer_pkg;

  localparam int unsigned N_DEFAULT               = 16;
  localparam int unsigned DIRECTION_WIDTH_DEFAULT = 4;
  localparam int unsigned POSITION_WIDTH_DEFAULT  = 16;
  localparam int unsigned ADDR_WIDTH_DEFAULT      = 12;

  // Direction code meaning stop / invalid cell; used for masked rows.
  localparam int unsigned DIR_STOP = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/traceback_column_writer_deskew_line.sv
// DEPTH-stage shift register with enable; DEPTH = 0 degenerates to a wire.
module traceback_deskew_line
  import traceback_column_writer_pkg::*;
#(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = DIRECTION_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst_n, en};
    assign dout        = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift one stage per accepted array step; stall holds contents.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else if (en) begin
        stage_q[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/traceback_column_writer.sv
// Deskews systolic-array direction lanes into column words and writes them
// to the traceback memory, one word per reference position.
module traceback_column_writer
  import traceback_column_writer_pkg::*;
#(
  parameter int unsigned N               = N_DEFAULT,
  parameter int unsigned DIRECTION_WIDTH = DIRECTION_WIDTH_DEFAULT,
  parameter int unsigned POSITION_WIDTH  = POSITION_WIDTH_DEFAULT,
  parameter int unsigned ADDR_WIDTH      = ADDR_WIDTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [POSITION_WIDTH-1:0]    ref_length,
  input  logic [$clog2(N):0]           query_rows,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic                         array_valid,
  output logic                         array_ready,
  input  logic [N*DIRECTION_WIDTH-1:0] pe_dir_in,
  output logic                         mem_wr_valid,
  input  logic                         mem_wr_ready,
  output logic [ADDR_WIDTH-1:0]        mem_wr_addr,
  output logic [N*DIRECTION_WIDTH-1:0] mem_wr_data,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned LOG_N = $clog2(N);
  localparam int unsigned QW    = LOG_N + 1;
  localparam int unsigned SW    = POSITION_WIDTH + 1;
  localparam int unsigned WW    = N * DIRECTION_WIDTH;

  state_t                  state_q, state_d;
  logic [SW-1:0]           s_q, s_d;
  logic [SW-1:0]           total_q, total_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [QW-1:0]           rows_q, rows_d;
  logic                    valid_d, done_d, busy_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [WW-1:0]           data_d;
  logic [WW-1:0]           col_word;
  logic [DIRECTION_WIDTH-1:0] lane_out [N];
  logic                    advance, accept, complete, load;

  // Zero and oversize row counts both mean a full column.
  function automatic logic [QW-1:0] clamp_rows(input logic [QW-1:0] q);
    logic [QW-1:0] r;
    r = q;
    if (q == '0 || q > QW'(N)) r = QW'(N);
    return r;
  endfunction

  assign array_ready = (state_q == ST_RUN) && (!mem_wr_valid || mem_wr_ready);
  assign advance     = array_valid && array_ready;
  assign accept      = mem_wr_valid && mem_wr_ready;
  assign complete    = (s_q >= SW'(N - 1));
  assign load        = advance && complete;

  // Lane r lags lane r-1 by one step, so it needs N-1-r stages to line up.
  for (genvar r = 0; r < N; r++) begin : g_lane
    traceback_deskew_line #(
      .DEPTH (N - 1 - r),
      .WIDTH (DIRECTION_WIDTH)
    ) u_line (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (advance),
      .din   (pe_dir_in[r*DIRECTION_WIDTH +: DIRECTION_WIDTH]),
      .dout  (lane_out[r])
    );
  end

  // Pack the aligned lanes row 0 first (MSBs), blanking rows beyond the query.
  always_comb begin
    col_word = '0;
    for (int unsigned r = 0; r < N; r++) begin
      col_word[(N-1-r)*DIRECTION_WIDTH +: DIRECTION_WIDTH] =
        (r < 32'(rows_q)) ? lane_out[r] : DIRECTION_WIDTH'(DIR_STOP);
    end
  end

  // Next-state, counters and output-register next values.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    total_d = total_q;
    base_d  = base_q;
    rows_d  = rows_q;
    valid_d = mem_wr_valid;
    addr_d  = mem_wr_addr;
    data_d  = mem_wr_data;
    done_d  = 1'b0;

    if (load) begin
      valid_d = 1'b1;
      addr_d  = base_q + ADDR_WIDTH'(s_q - SW'(N - 1));
      data_d  = col_word;
    end else if (accept) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          total_d = SW'((ref_length == '0) ? POSITION_WIDTH'(1) : ref_length) + SW'(N - 1);
          base_d  = base_addr;
          rows_d  = clamp_rows(query_rows);
          s_d     = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (advance) begin
          s_d = s_q + SW'(1);
          if (s_q + SW'(1) == total_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (accept) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, counters, latched block parameters and the write register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      s_q          <= '0;
      total_q      <= '0;
      base_q       <= '0;
      rows_q       <= '0;
      mem_wr_valid <= 1'b0;
      mem_wr_addr  <= '0;
      mem_wr_data  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      total_q      <= total_d;
      base_q       <= base_d;
      rows_q       <= rows_d;
      mem_wr_valid <= valid_d;
      mem_wr_addr  <= addr_d;
      mem_wr_data  <= data_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

endmodule

// File: tb/tb_traceback_column_writer.sv
// Directed bench for traceback_column_writer at N=4, DW=4, ADDR_WIDTH=8.
module tb_traceback_column_writer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] ref_length;
  logic [2:0]  query_rows;
  logic [7:0]  base_addr;
  logic        array_valid;
  logic        array_ready;
  logic [15:0] pe_dir_in;
  logic        mem_wr_valid;
  logic        mem_wr_ready;
  logic [7:0]  mem_wr_addr;
  logic [15:0] mem_wr_data;
  logic        busy;
  logic        done;

  traceback_column_writer #(
    .N               (4),
    .DIRECTION_WIDTH (4),
    .POSITION_WIDTH  (16),
    .ADDR_WIDTH      (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .ref_length   (ref_length),
    .query_rows   (query_rows),
    .base_addr    (base_addr),
    .array_valid  (array_valid),
    .array_ready  (array_ready),
    .pe_dir_in    (pe_dir_in),
    .mem_wr_valid (mem_wr_valid),
    .mem_wr_ready (mem_wr_ready),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  base;
    logic [15:0] len;
    logic [2:0]  rows;
    int          mode;      // 0: lane r step s -> s-r+1, 1: all lanes 4'hF
    bit          stall;     // array_valid toggles 1,0,1,0
    bit          bp;        // hold mem_wr_ready low 3 cycles on the second write
    bit          mid;       // extra start pulse mid-block
    int          exp_n;
    logic [7:0]  exp_addr [5];
    logic [15:0] exp_data [5];
    int          exp_adv;
    int          exp_lat;
  } vec_t;

  vec_t vecs [8];

  int tests = 0;
  int fails = 0;

  logic [7:0]  wr_addr [$];
  logic [15:0] wr_data [$];
  int          wr_cyc  [$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          adv_cnt = 0;
  int          first_adv = -1;
  int          first_val = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pattern(input int mode, input int step);
    logic [15:0] w;
    int v;
    w = '0;
    for (int r = 0; r < 4; r++) begin
      v = step - r + 1;
      if (v < 0) v = 0;
      if (mode == 1) v = 15;
      w[r*4 +: 4] = 4'(v);
    end
    return w;
  endfunction

  // Observe handshakes mid-cycle, well away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (mem_wr_valid && mem_wr_ready) begin
        wr_addr.push_back(mem_wr_addr);
        wr_data.push_back(mem_wr_data);
        wr_cyc.push_back(cyc);
      end
      if (done) done_cnt++;
      if (array_valid && array_ready) begin
        adv_cnt++;
        if (first_adv < 0) first_adv = cyc;
      end
      if (mem_wr_valid && first_val < 0) first_val = cyc;
    end
  end

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cnt  = 0;
    adv_cnt   = 0;
    first_adv = -1;
    first_val = -1;
  endtask

  task automatic run_block(input vec_t v, input int idx);
    int step, hold, cycles;
    bit toggle, seen_done, mid_done;
    logic [7:0]  a;
    logic [15:0] d;
    clear_mon();
    @(posedge clk); #1;
    start      = 1'b1;
    base_addr  = v.base;
    ref_length = v.len;
    query_rows = v.rows;
    @(posedge clk); #1;
    start      = 1'b0;
    base_addr  = 8'hA5;
    ref_length = 16'd1;
    query_rows = 3'd1;
    chk($sformatf("v%0d busy_after_start", idx), 32'(busy), 32'd1);

    step = 0; hold = 0; toggle = 1'b1; seen_done = 1'b0; mid_done = 1'b0; cycles = 0;
    while (!seen_done && cycles < 200) begin
      array_valid  = v.stall ? toggle : 1'b1;
      toggle       = !toggle;
      pe_dir_in    = pattern(v.mode, step);
      mem_wr_ready = 1'b1;
      if (v.bp && mem_wr_valid && mem_wr_addr == v.exp_addr[1] && hold < 3) begin
        mem_wr_ready = 1'b0;
        hold++;
      end
      start = v.mid && (step == 2) && !mid_done;
      if (start) mid_done = 1'b1;
      @(negedge clk);
      if (!mem_wr_ready) begin
        chk($sformatf("v%0d bp_array_ready", idx), 32'(array_ready), 32'd0);
        chk($sformatf("v%0d bp_addr_hold", idx), 32'(mem_wr_addr), 32'(v.exp_addr[1]));
        chk($sformatf("v%0d bp_data_hold", idx), 32'(mem_wr_data), 32'(v.exp_data[1]));
      end
      if (array_valid && array_ready) step++;
      if (done) seen_done = 1'b1;
      cycles++;
      @(posedge clk); #1;
      start = 1'b0;
    end
    array_valid = 1'b0;
    chk($sformatf("v%0d done_seen", idx), 32'(seen_done), 32'd1);
    chk($sformatf("v%0d busy_end", idx), 32'(busy), 32'd0);
    chk($sformatf("v%0d done_pulse_end", idx), 32'(done), 32'd0);
    chk($sformatf("v%0d valid_end", idx), 32'(mem_wr_valid), 32'd0);
    chk($sformatf("v%0d write_count", idx), 32'(wr_addr.size()), 32'(v.exp_n));
    for (int i = 0; i < v.exp_n; i++) begin
      a = (i < wr_addr.size()) ? wr_addr[i] : 8'hxx;
      d = (i < wr_data.size()) ? wr_data[i] : 16'hxxxx;
      chk($sformatf("v%0d addr%0d", idx, i), 32'(a), 32'(v.exp_addr[i]));
      chk($sformatf("v%0d data%0d", idx, i), 32'(d), 32'(v.exp_data[i]));
    end
    chk($sformatf("v%0d done_count", idx), 32'(done_cnt), 32'd1);
    chk($sformatf("v%0d advances", idx), 32'(adv_cnt), 32'(v.exp_adv));
    chk($sformatf("v%0d first_latency", idx), 32'(first_val - first_adv), 32'(v.exp_lat));
    if (v.stall) begin
      for (int i = 1; i < wr_cyc.size(); i++)
        chk($sformatf("v%0d write_gap%0d", idx, i), 32'(wr_cyc[i] - wr_cyc[i-1]), 32'd2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    int step;
    vecs[0] = '{base:8'h10, len:16'd3, rows:3'd4, mode:0, stall:1'b0, bp:1'b0, mid:1'b0, exp_n:3,
                exp_addr:'{8'h10, 8'h11, 8'h12, 8'h00, 8'h00},
                exp_data:'{16'h1111, 16'h2222, 16'h3333, 16'h0000, 16'h0000}, exp_adv:6, exp_lat:4};
    vecs[1] = '{base:8'h10, len:16'd3, rows:3'd4, mode:0, stall:1'b0, bp:1'b1, mid:1'b0, exp_n:3,
                exp_addr:'{8'h10, 8'h11, 8'h12, 8'h00, 8'h00},
                exp_data:'{16'h1111, 16'h2222, 16'h3333, 16'h0000, 16'h0000}, exp_adv:6, exp_lat:4};
    vecs[2] = '{base:8'h20, len:16'd2, rows:3'd2, mode:1, stall:1'b0, bp:1'b0, mid:1'b0, exp_n:2,
                exp_addr:'{8'h20, 8'h21, 8'h00, 8'h00, 8'h00},
                exp_data:'{16'hFF00, 16'hFF00, 16'h0000, 16'h0000, 16'h0000}, exp_adv:5, exp_lat:4};
    vecs[3] = '{base:8'hFF, len:16'd2, rows:3'd4, mode:0, stall:1'b0, bp:1'b0, mid:1'b0, exp_n:2,
                exp_addr:'{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00},
                exp_data:'{16'h1111, 16'h2222, 16'h0000, 16'h0000, 16'h0000}, exp_adv:5, exp_lat:4};
    vecs[4] = '{base:8'h30, len:16'd5, rows:3'd4, mode:0, stall:1'b1, bp:1'b0, mid:1'b0, exp_n:5,
                exp_addr:'{8'h30, 8'h31, 8'h32, 8'h33, 8'h34},
                exp_data:'{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555}, exp_adv:8, exp_lat:7};
    vecs[5] = '{base:8'h40, len:16'd1, rows:3'd0, mode:0, stall:1'b0, bp:1'b0, mid:1'b0, exp_n:1,
                exp_addr:'{8'h40, 8'h00, 8'h00, 8'h00, 8'h00},
                exp_data:'{16'h1111, 16'h0000, 16'h0000, 16'h0000, 16'h0000}, exp_adv:4, exp_lat:4};
    vecs[6] = '{base:8'h50, len:16'd0, rows:3'd5, mode:0, stall:1'b0, bp:1'b0, mid:1'b0, exp_n:1,
                exp_addr:'{8'h50, 8'h00, 8'h00, 8'h00, 8'h00},
                exp_data:'{16'h1111, 16'h0000, 16'h0000, 16'h0000, 16'h0000}, exp_adv:4, exp_lat:4};
    vecs[7] = '{base:8'h60, len:16'd3, rows:3'd4, mode:0, stall:1'b0, bp:1'b0, mid:1'b1, exp_n:3,
                exp_addr:'{8'h60, 8'h61, 8'h62, 8'h00, 8'h00},
                exp_data:'{16'h1111, 16'h2222, 16'h3333, 16'h0000, 16'h0000}, exp_adv:6, exp_lat:4};

    rst_n = 1'b0; start = 1'b0; ref_length = '0; query_rows = '0; base_addr = '0;
    array_valid = 1'b0; pe_dir_in = '0; mem_wr_ready = 1'b0;
    #1;
    chk("reset_valid", 32'(mem_wr_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_array_ready", 32'(array_ready), 32'd0);
    chk("reset_addr", 32'(mem_wr_addr), 32'd0);
    chk("reset_data", 32'(mem_wr_data), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // array_valid while idle is not accepted
    array_valid = 1'b1; mem_wr_ready = 1'b1; pe_dir_in = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("idle_array_ready%0d", i), 32'(array_ready), 32'd0);
      chk($sformatf("idle_valid%0d", i), 32'(mem_wr_valid), 32'd0);
      chk($sformatf("idle_busy%0d", i), 32'(busy), 32'd0);
    end
    @(posedge clk); #1 array_valid = 1'b0;

    for (int i = 0; i < 8; i++) run_block(vecs[i], i);

    // Reset in the middle of a block aborts without done
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'h70; ref_length = 16'd3; query_rows = 3'd4;
    @(posedge clk); #1;
    start = 1'b0;
    step = 0;
    for (int i = 0; i < 5; i++) begin
      array_valid = 1'b1; mem_wr_ready = 1'b1; pe_dir_in = pattern(0, step);
      @(negedge clk);
      if (array_valid && array_ready) step++;
      @(posedge clk); #1;
    end
    chk("rst_pre_valid", 32'(mem_wr_valid), 32'd1);
    chk("rst_pre_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(mem_wr_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_array_ready", 32'(array_ready), 32'd0);
    array_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_done", 32'(done_cnt), 32'd0);
    chk("rst_idle_busy", 32'(busy), 32'd0);

    run_block(vecs[0], 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
